// File: rtl/hdr_flit_inject_scheduler_if.sv
// Requester, flit and credit signals between the core-side packet sources
// and the local-port injection scheduler.
interface hdr_flit_inject_scheduler_if #(
  parameter int N     = 4,
  parameter int V     = 4,
  parameter int Fpay  = 32,
  parameter int EAw   = 4,
  parameter int DSTPw = 4,
  parameter int C     = 4,
  parameter int Lw    = 5
);
  localparam int Cw = (C > 1) ? $clog2(C) : 1;
  localparam int Fw = 2 + V + Fpay;

  logic [EAw-1:0]     src_e_addr;
  logic [N-1:0]       req;
  logic [N*EAw-1:0]   req_dest_e_addr;
  logic [N*DSTPw-1:0] req_destport;
  logic [N*Cw-1:0]    req_class;
  logic [N*Lw-1:0]    req_len;
  logic [N*Fpay-1:0]  req_data;
  logic [N-1:0]       grant;
  logic [N-1:0]       data_rd;
  logic [Fw-1:0]      flit_out;
  logic               flit_out_wr;
  logic [V-1:0]       credit_in;
  logic               credit_err;

  modport slave (
    input  src_e_addr, req, req_dest_e_addr, req_destport, req_class,
           req_len, req_data, credit_in,
    output grant, data_rd, flit_out, flit_out_wr, credit_err
  );

  modport master (
    output src_e_addr, req, req_dest_e_addr, req_destport, req_class,
           req_len, req_data, credit_in,
    input  grant, data_rd, flit_out, flit_out_wr, credit_err
  );
endinterface

// File: rtl/hdr_flit_inject_scheduler.sv
// Round-robin packet injection scheduler: picks a requester and an idle VC,
// emits header then body/tail flits under per-VC credit flow control.
//
// state | meaning
// IDLE  | arbitrate; needs a request and a VC whose counter is full
// HDR   | emit header flit once the chosen VC has a credit
// BODY  | emit body/tail flits, popping the granted requester's data
module hdr_flit_inject_scheduler #(
  parameter int N     = 4,
  parameter int V     = 4,
  parameter int Fpay  = 32,
  parameter int EAw   = 4,
  parameter int DSTPw = 4,
  parameter int C     = 4,
  parameter int B     = 4,
  parameter int Lw    = 5
) (
  input logic                        clk,
  input logic                        reset,
  hdr_flit_inject_scheduler_if.slave bus
);
  localparam int Cw  = (C > 1) ? $clog2(C) : 1;
  localparam int Fw  = 2 + V + Fpay;
  localparam int CRw = $clog2(B + 1);
  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam int VW  = (V > 1) ? $clog2(V) : 1;
  localparam logic [CRw-1:0] CR_FULL = CRw'(B);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t           state_q;
  logic [NW-1:0]    rr_ptr_q;
  logic [NW-1:0]    gidx_q;
  logic [VW-1:0]    vidx_q;
  logic [EAw-1:0]   dest_q;
  logic [DSTPw-1:0] dport_q;
  logic [Cw-1:0]    cls_q;
  logic [Lw-1:0]    len_q;
  logic [Lw-1:0]    rem_q;
  logic [N-1:0]     grant_q;
  logic [Fw-1:0]    flit_q;
  logic             wr_q;
  logic             err_q;
  logic             err_d;
  logic [CRw-1:0]   cnt_q [V];
  logic [CRw-1:0]   cnt_d [V];

  logic             win_vld;
  logic [NW-1:0]    win_idx;
  logic             vc_vld;
  logic [VW-1:0]    vc_idx;
  logic [Lw-1:0]    win_len;
  logic             crd_ok;
  logic             load;
  logic [V-1:0]     vc_oh;
  logic [V-1:0]     dec_v;
  logic [Fpay-1:0]  hdr_pay;
  logic [Fpay-1:0]  gdata;
  logic [1:0]       hdr_flags;
  logic [1:0]       body_flags;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_vld && bus.req[(int'(rr_ptr_q) + k) % N]) begin
        win_vld = 1'b1;
        win_idx = NW'((int'(rr_ptr_q) + k) % N);
      end
    end
  end

  // Only a downstream VC with all credits home counts as idle.
  always_comb begin
    vc_vld = 1'b0;
    vc_idx = '0;
    for (int v = 0; v < V; v++) begin
      if (!vc_vld && cnt_q[v] == CR_FULL) begin
        vc_vld = 1'b1;
        vc_idx = VW'(v);
      end
    end
  end

  always_comb begin
    hdr_pay = '0;
    hdr_pay[0 +: EAw]         = bus.src_e_addr;
    hdr_pay[EAw +: EAw]       = dest_q;
    hdr_pay[2*EAw +: DSTPw]   = dport_q;
    if (C > 1) begin
      hdr_pay[2*EAw+DSTPw +: Cw] = cls_q;
    end
  end

  assign win_len    = bus.req_len[win_idx*Lw +: Lw];
  assign gdata      = bus.req_data[gidx_q*Fpay +: Fpay];
  assign crd_ok     = (cnt_q[vidx_q] != '0);
  assign load       = crd_ok && (state_q == HDR || state_q == BODY);
  assign vc_oh      = V'(1) << vidx_q;
  assign dec_v      = load ? vc_oh : '0;
  assign hdr_flags  = (len_q == Lw'(1)) ? 2'b11 : 2'b10;
  assign body_flags = (rem_q == Lw'(1)) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      vidx_q   <= '0;
      dest_q   <= '0;
      dport_q  <= '0;
      cls_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      grant_q  <= '0;
      flit_q   <= '0;
      wr_q     <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld && vc_vld) begin
            gidx_q   <= win_idx;
            vidx_q   <= vc_idx;
            dest_q   <= bus.req_dest_e_addr[win_idx*EAw +: EAw];
            dport_q  <= bus.req_destport[win_idx*DSTPw +: DSTPw];
            cls_q    <= bus.req_class[win_idx*Cw +: Cw];
            len_q    <= (win_len == '0) ? Lw'(1) : win_len;
            grant_q  <= N'(1) << win_idx;
            rr_ptr_q <= NW'((int'(win_idx) + 1) % N);
            state_q  <= HDR;
          end
        end
        HDR: begin
          if (crd_ok) begin
            flit_q <= {hdr_flags, vc_oh, hdr_pay};
            wr_q   <= 1'b1;
            if (len_q == Lw'(1)) begin
              grant_q <= '0;
              state_q <= IDLE;
            end else begin
              rem_q   <= len_q - Lw'(1);
              state_q <= BODY;
            end
          end
        end
        BODY: begin
          if (crd_ok) begin
            flit_q <= {body_flags, vc_oh, gdata};
            wr_q   <= 1'b1;
            rem_q  <= rem_q - Lw'(1);
            if (rem_q == Lw'(1)) begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A send and a return on the same VC in one cycle cancel out.
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < V; v++) begin
      cnt_d[v] = cnt_q[v];
      if (dec_v[v] && !bus.credit_in[v]) begin
        cnt_d[v] = cnt_q[v] - CRw'(1);
      end else if (bus.credit_in[v] && !dec_v[v]) begin
        if (cnt_q[v] == CR_FULL) begin
          err_d = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] + CRw'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < V; v++) begin
        cnt_q[v] <= CR_FULL;
      end
      err_q <= 1'b0;
    end else begin
      for (int v = 0; v < V; v++) begin
        cnt_q[v] <= cnt_d[v];
      end
      err_q <= err_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.data_rd     = (state_q == BODY && crd_ok) ? grant_q : '0;
  assign bus.flit_out    = flit_q;
  assign bus.flit_out_wr = wr_q;
  assign bus.credit_err  = err_q;

endmodule

// File: tb/tb_hdr_flit_inject_scheduler.sv
// Directed bench for the injection scheduler: cycle-exact flit, grant,
// data_rd and credit behaviour against hand-computed expectations.
module tb_hdr_flit_inject_scheduler;
  localparam int N = 4, V = 4, Fpay = 32, EAw = 4, DSTPw = 4, C = 4, B = 4, Lw = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  hdr_flit_inject_scheduler_if #(.N(N), .V(V), .Fpay(Fpay), .EAw(EAw),
    .DSTPw(DSTPw), .C(C), .Lw(Lw)) bus ();

  hdr_flit_inject_scheduler #(.N(N), .V(V), .Fpay(Fpay), .EAw(EAw),
    .DSTPw(DSTPw), .C(C), .B(B), .Lw(Lw)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Header with source address 4'hA.
  function automatic logic [63:0] hdr(input logic [3:0] dst, input logic [3:0] dp,
                                      input logic [1:0] cls, input logic [3:0] vc,
                                      input logic [1:0] fl);
    logic [63:0] r;
    r = '0;
    r[3:0]   = 4'hA;
    r[7:4]   = dst;
    r[11:8]  = dp;
    r[13:12] = cls;
    r[35:32] = vc;
    r[37:36] = fl;
    return r;
  endfunction

  function automatic logic [63:0] body(input logic [3:0] vc, input logic [1:0] fl,
                                       input logic [31:0] d);
    return {26'd0, fl, vc, d};
  endfunction

  task automatic set_req(input int i, input logic [3:0] d, input logic [3:0] dp,
                         input logic [1:0] c, input logic [4:0] l, input logic [31:0] w);
    bus.req_dest_e_addr[i*EAw +: EAw] = d;
    bus.req_destport[i*DSTPw +: DSTPw] = dp;
    bus.req_class[i*2 +: 2]            = c;
    bus.req_len[i*Lw +: Lw]            = l;
    bus.req_data[i*Fpay +: Fpay]       = w;
  endtask

  initial begin
    reset = 1'b0;
    bus.src_e_addr      = 4'hA;
    bus.req             = '0;
    bus.req_dest_e_addr = '0;
    bus.req_destport    = '0;
    bus.req_class       = '0;
    bus.req_len         = '0;
    bus.req_data        = '0;
    bus.credit_in       = '0;
    tick(2);
    chk("rst_grant", 64'(bus.grant), 64'h0);
    chk("rst_data_rd", 64'(bus.data_rd), 64'h0);
    chk("rst_flit", 64'(bus.flit_out), 64'h0);
    chk("rst_wr", 64'(bus.flit_out_wr), 64'h0);
    chk("rst_err", 64'(bus.credit_err), 64'h0);
    reset = 1'b1;
    tick();

    // Three-flit packet from requester 0.
    set_req(0, 4'h5, 4'h3, 2'd2, 5'd3, 32'h1111_0000);
    bus.req = 4'b0001;
    tick();
    chk("p1_grant", 64'(bus.grant), 64'h1);
    chk("p1_wr_before_hdr", 64'(bus.flit_out_wr), 64'h0);
    chk("p1_rd_in_hdr", 64'(bus.data_rd), 64'h0);
    bus.req = 4'b0000;
    tick();
    chk("p1_hdr", 64'(bus.flit_out), hdr(4'h5, 4'h3, 2'd2, 4'b0001, 2'b10));
    chk("p1_hdr_wr", 64'(bus.flit_out_wr), 64'h1);
    chk("p1_rd1", 64'(bus.data_rd), 64'h1);
    tick();
    chk("p1_body", 64'(bus.flit_out), body(4'b0001, 2'b00, 32'h1111_0000));
    chk("p1_rd2", 64'(bus.data_rd), 64'h1);
    bus.req_data[31:0] = 32'h2222_0001;
    tick();
    chk("p1_tail", 64'(bus.flit_out), body(4'b0001, 2'b01, 32'h2222_0001));
    chk("p1_grant_drop", 64'(bus.grant), 64'h0);
    chk("p1_rd_after", 64'(bus.data_rd), 64'h0);
    tick();
    chk("p1_wr_pulse", 64'(bus.flit_out_wr), 64'h0);
    chk("p1_flit_hold", 64'(bus.flit_out), body(4'b0001, 2'b01, 32'h2222_0001));

    // VC0 has 1 credit left, so next packet takes VC1.
    set_req(0, 4'h6, 4'h3, 2'd2, 5'd1, 32'h0);
    bus.req = 4'b0001;
    tick();
    chk("p2_grant", 64'(bus.grant), 64'h1);
    bus.req = 4'b0000;
    tick();
    chk("p2_hdr_vc1", 64'(bus.flit_out), hdr(4'h6, 4'h3, 2'd2, 4'b0010, 2'b11));
    chk("p2_grant_drop", 64'(bus.grant), 64'h0);

    // Return VC0 credits to full, then one extra.
    bus.credit_in = 4'b0001;
    tick(3);
    chk("err_at_full", 64'(bus.credit_err), 64'h0);
    tick();
    bus.credit_in = 4'b0000;
    chk("err_set", 64'(bus.credit_err), 64'h1);
    tick(3);
    chk("err_sticky", 64'(bus.credit_err), 64'h1);

    reset = 1'b0;
    #1;
    chk("rst2_err", 64'(bus.credit_err), 64'h0);
    chk("rst2_flit", 64'(bus.flit_out), 64'h0);
    tick();
    reset = 1'b1;
    tick();

    // Round robin over all four single-flit requesters.
    for (int k = 0; k < 4; k++) begin
      set_req(k, 4'(k + 8), 4'(k), 2'(k), 5'd1, 32'h0);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", 64'(bus.grant), 64'(4'b0001 << k));
      tick();
      chk("rr_hdr", 64'(bus.flit_out),
          hdr(4'(k + 8), 4'(k), 2'(k), 4'(4'b0001 << k), 2'b11));
    end
    bus.credit_in = 4'b1111;
    tick();
    bus.credit_in = 4'b0000;
    chk("rr_no_idle_vc", 64'(bus.grant), 64'h0);
    tick();
    chk("rr_wrap_grant", 64'(bus.grant), 64'h1);
    bus.req = 4'b0000;
    tick();
    chk("rr_wrap_hdr", 64'(bus.flit_out), hdr(4'h8, 4'h0, 2'd0, 4'b0001, 2'b11));

    // Eight-flit packet on VC1 stalls after four flits.
    set_req(2, 4'hC, 4'h7, 2'd1, 5'd8, 32'hD000_0000);
    bus.req = 4'b0100;
    tick();
    chk("st_grant", 64'(bus.grant), 64'h4);
    bus.req = 4'b0000;
    tick();
    chk("st_hdr", 64'(bus.flit_out), hdr(4'hC, 4'h7, 2'd1, 4'b0010, 2'b10));
    tick(3);
    chk("st_4th_wr", 64'(bus.flit_out_wr), 64'h1);
    chk("st_4th", 64'(bus.flit_out), body(4'b0010, 2'b00, 32'hD000_0000));
    chk("st_rd_stop", 64'(bus.data_rd), 64'h0);
    tick();
    chk("st_wr_stall", 64'(bus.flit_out_wr), 64'h0);
    tick();
    chk("st_wr_stall2", 64'(bus.flit_out_wr), 64'h0);
    bus.credit_in = 4'b0010;
    #1;
    chk("st_credit_same_cycle", 64'(bus.data_rd), 64'h0);
    tick();
    bus.credit_in = 4'b0000;
    chk("st_resume_rd", 64'(bus.data_rd), 64'h4);
    bus.req_data[2*Fpay +: Fpay] = 32'hCAFE_0005;
    tick();
    chk("st_resume_flit", 64'(bus.flit_out), body(4'b0010, 2'b00, 32'hCAFE_0005));
    chk("st_one_per_credit", 64'(bus.data_rd), 64'h0);
    tick();
    chk("st_wr_after_one", 64'(bus.flit_out_wr), 64'h0);
    bus.credit_in = 4'b0010;
    tick();
    chk("sim_rd_pre", 64'(bus.data_rd), 64'h4);
    bus.req_data[2*Fpay +: Fpay] = 32'hCAFE_0006;
    tick();
    bus.credit_in = 4'b0000;
    chk("sim_flit", 64'(bus.flit_out), body(4'b0010, 2'b00, 32'hCAFE_0006));
    chk("sim_cnt_unchanged", 64'(bus.data_rd), 64'h4);
    bus.req_data[2*Fpay +: Fpay] = 32'hCAFE_0007;
    tick();
    chk("sim_last_flit", 64'(bus.flit_out), body(4'b0010, 2'b00, 32'hCAFE_0007));
    chk("sim_rd_stop", 64'(bus.data_rd), 64'h0);
    chk("sim_grant_held", 64'(bus.grant), 64'h4);

    // Reset in the middle of the body.
    tick();
    bus.credit_in = 4'b0010;
    tick();
    bus.credit_in = 4'b0000;
    chk("mr_rd_before", 64'(bus.data_rd), 64'h4);
    reset = 1'b0;
    #1;
    chk("mr_grant", 64'(bus.grant), 64'h0);
    chk("mr_rd", 64'(bus.data_rd), 64'h0);
    chk("mr_flit", 64'(bus.flit_out), 64'h0);
    chk("mr_wr", 64'(bus.flit_out_wr), 64'h0);
    tick(2);
    reset = 1'b1;
    tick();
    chk("mr_no_partial", 64'(bus.flit_out_wr), 64'h0);
    set_req(2, 4'h9, 4'h1, 2'd3, 5'd2, 32'hBEEF_0001);
    bus.req = 4'b0100;
    tick();
    chk("mr_grant_fresh", 64'(bus.grant), 64'h4);
    bus.req = 4'b0000;
    tick();
    chk("mr_hdr_vc0", 64'(bus.flit_out), hdr(4'h9, 4'h1, 2'd3, 4'b0001, 2'b10));
    chk("mr_rd", 64'(bus.data_rd), 64'h4);
    tick();
    chk("mr_tail", 64'(bus.flit_out), body(4'b0001, 2'b01, 32'hBEEF_0001));
    chk("mr_grant_drop", 64'(bus.grant), 64'h0);

    // Zero length behaves as a single-flit packet.
    set_req(0, 4'h3, 4'h2, 2'd1, 5'd0, 32'h0);
    bus.req = 4'b0001;
    tick();
    chk("l0_grant", 64'(bus.grant), 64'h1);
    bus.req = 4'b0000;
    tick();
    chk("l0_hdr", 64'(bus.flit_out), hdr(4'h3, 4'h2, 2'd1, 4'b0010, 2'b11));
    chk("l0_wr", 64'(bus.flit_out_wr), 64'h1);
    chk("l0_grant_drop", 64'(bus.grant), 64'h0);
    tick();
    chk("l0_wr_end", 64'(bus.flit_out_wr), 64'h0);
    chk("l0_rd", 64'(bus.data_rd), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
